// File: rtl/debounce_if.sv
// Button-side signal bundle for the debouncer: raw button level out, press pulse back.
// The debouncer keeps plain clk/rst/btn/raise ports; the bundle connects to them by name.
interface debounce_if;
    logic btn;
    logic raise;

    modport master (output btn, input raise);
    modport slave  (input btn, output raise);
endinterface

// File: rtl/debounce.sv
// Button debouncer: 2-flop synchronizer, then a level filter that needs 2^N agreeing cycles
// before it accepts a new level. Emits a one-cycle pulse on every accepted press.
module debounce #(
    parameter int DEBOUNCE_CNT = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic raise
);

    localparam logic [DEBOUNCE_CNT-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    logic                    s1      = 1'b0;
    logic                    s2      = 1'b0;
    state_t                  state   = ST_LOW;
    logic [DEBOUNCE_CNT-1:0] cnt     = '0;
    logic                    raise_q = 1'b0;

    state_t                  state_nxt;
    logic [DEBOUNCE_CNT-1:0] cnt_nxt;
    logic                    raise_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            state   <= ST_LOW;
            cnt     <= '0;
            raise_q <= 1'b0;
        end else begin
            s1      <= btn;
            s2      <= s1;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            raise_q <= raise_nxt;
        end
    end

    // Any cycle of agreement restarts the count; the count saturates into a level change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        raise_nxt = 1'b0;
        if (s2 != state) begin
            if (cnt == CNT_MAX) begin
                state_nxt = state_t'(s2);
                raise_nxt = s2;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    assign raise = raise_q;

endmodule

// File: tb/tb_debounce.sv
// Directed bench for the debouncer with an 8-cycle window (DEBOUNCE_CNT = 3).
module tb_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    debounce_if bus ();

    debounce #(.DEBOUNCE_CNT(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn),
        .raise (bus.raise)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic obs, input logic exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input logic [2:0] exp, input string tag);
        n_cmp++;
        assert (dut.cnt === exp) else begin
            n_err++;
            $error("FAIL %s observed cnt=%0d expected=%0d", tag, dut.cnt, exp);
        end
    endtask

    // Advance one rising edge and sample raise 1 time unit later.
    task automatic edge_chk(input logic exp, input string tag);
        @(posedge clk);
        #1;
        chk(bus.raise, exp, tag);
    endtask

    task automatic quiet(input logic lvl, input int n, input string tag);
        bus.btn = lvl;
        for (int i = 0; i < n; i++) edge_chk(1'b0, tag);
    endtask

    initial begin
        bus.btn = 1'b0;
        rst     = 1'b1;

        // Reset: two cycles
        edge_chk(1'b0, "reset_raise0");
        edge_chk(1'b0, "reset_raise1");
        chk(dut.state, 1'b0, "reset_state");
        chk_cnt(3'd0, "reset_cnt");

        // Clean press: btn high from E0, pulse after E9 only
        rst     = 1'b0;
        bus.btn = 1'b1;
        for (int i = 0; i <= 9; i++) begin
            edge_chk(i == 9, "clean_press");
            if (i == 2) chk_cnt(3'd1, "clean_cnt_e2");
            if (i == 8) chk_cnt(3'd7, "clean_cnt_e8");
            if (i == 8) chk(dut.state, 1'b0, "clean_state_e8");
        end
        chk(dut.state, 1'b1, "clean_state_e9");
        quiet(1'b1, 20, "clean_hold");

        // Release silence: bouncing release never pulses
        quiet(1'b0, 3, "release_bounce_a");
        quiet(1'b1, 1, "release_bounce_b");
        quiet(1'b0, 15, "release_bounce_c");
        chk(dut.state, 1'b0, "release_state");

        // Bounce: 5 high, 1 low, then held; final rising sample at edge 6 -> pulse at edge 15
        bus.btn = 1'b1;
        for (int i = 0; i <= 24; i++) begin
            bus.btn = (i == 5) ? 1'b0 : 1'b1;
            edge_chk(i == 15, "bounce_press");
        end

        // Short release of 3 cycles leaves the press standing: no second pulse
        quiet(1'b0, 3, "short_release");
        quiet(1'b1, 15, "short_release_repress");
        chk(dut.state, 1'b1, "short_release_state");

        // Full release of 12 cycles, then re-press -> pulse 9 edges after re-press sample
        quiet(1'b0, 12, "full_release");
        chk(dut.state, 1'b0, "full_release_state");
        bus.btn = 1'b1;
        for (int i = 0; i <= 14; i++) edge_chk(i == 9, "repress");

        // Short glitch: 7 high samples then low -> nothing
        quiet(1'b0, 12, "pre_glitch_release");
        quiet(1'b1, 7, "glitch_high");
        quiet(1'b0, 15, "glitch_low");
        chk(dut.state, 1'b0, "glitch_state");

        // Reset mid-count at E5, btn held high: pulse at E15 (9 after first post-reset edge E6)
        bus.btn = 1'b1;
        for (int i = 0; i <= 4; i++) edge_chk(1'b0, "midreset_pre");
        rst = 1'b1;
        edge_chk(1'b0, "midreset_in_reset");
        chk_cnt(3'd0, "midreset_cnt");
        chk(dut.state, 1'b0, "midreset_state");
        rst = 1'b0;
        for (int j = 1; j <= 15; j++) edge_chk(j == 10, "midreset_post");
        quiet(1'b1, 10, "midreset_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
